pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush, replacing the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the datapath. Each stage carries one opaque data bundle and one control bundle. Flushed or empty slots present an all-zero control bundle, so downstream stages see a bubble. Back-pressure from a stalled stage propagates upstream without a combinational ready path.

## Interface
Parameters:
- DATA_W, 32: width of data bundle (operands, immediates, register indices).
- CTRL_W, 12: width of control bundle (aluOperation, memWrite, regWrite, ...); zeroed on bubble.
- CLEAR_DATA, 1: 1 = data bundle also zeroed on reset/flush; 0 = data left unchanged (saves enables).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- syncClr  in  1  synchronous flush (branch/jump squash); active high.
- inValid  in  1  upstream presents a transaction.
- inReady  out  1  stage can accept this cycle.
- inData  in  DATA_W  upstream data bundle.
- inCtrl  in  CTRL_W  upstream control bundle.
- outValid  out  1  outData/outCtrl hold a live transaction.
- outReady  in  1  downstream accepts this cycle (low = stall).
- outData  out  DATA_W  registered data bundle.
- outCtrl  out  CTRL_W  registered control bundle; 0 whenever outValid=0.
- occupancy  out  2  live entries held (0, 1, 2).

## Operation
- Transfer in: inValid & inReady at a rising edge. Transfer out: outValid & outReady at a rising edge.
- Storage: main slot (drives outputs) plus skid slot.
- inReady = (state != FULL) & reset; decoded from state register only. No path from outReady to inReady.
- State EMPTY (occupancy 0):
  - in transfer → BUSY, main ← in.
- State BUSY (occupancy 1):
  - in only → FULL, skid ← in.
  - in and out → BUSY, main ← in.
  - out only → EMPTY.
  - neither → hold.
- State FULL (occupancy 2):
  - out transfer → BUSY, main ← skid.
  - otherwise hold.
  - inReady=0.
- Ordering is strict FIFO; no transaction is duplicated or dropped except by flush.
- syncClr: has priority over every transfer in that cycle.
  - Next state EMPTY.
  - Both slots are invalidated and their ctrl set to 0; data set to 0 if CLEAR_DATA=1.
  - A concurrent in transfer is discarded; the upstream flush owns it.
- Bubble rule: outCtrl is forced to 0 whenever outValid=0, so downstream regWrite/memWrite are never asserted by a dead slot.
- reset low (sampled at edge):
  - state EMPTY, outValid=0, outCtrl=0, outData=0 (regardless of CLEAR_DATA), occupancy=0, skid cleared.
  - inReady=0 while reset is low and 1 from the first cycle after release.
  - reset has priority over syncClr.

## Timing
- Latency: in transfer at edge N → outValid/outData at edge N visible in cycle N+1 (one cycle).
- Throughput: one transaction per cycle while outReady=1.
- Stall: outReady low for k cycles with continuous inValid → the stage absorbs exactly 2 entries.
  - inReady falls in the cycle after the second acceptance.
  - inReady rises one cycle after the first out transfer.
- Flush: outputs show a bubble in the cycle after syncClr; inReady=1 that same cycle.
- All outputs are registered except inReady and outCtrl gating, which are decoded from registers only.

## Configuration
- PIPE_STAGE_SKID_EN defined: behaviour as above, with a two-entry skid and a fully registered ready.
- PIPE_STAGE_SKID_EN undefined:
  - No skid slot; FULL state removed; occupancy ≤ 1.
  - inReady = ~outValid | outReady (combinational pass-through) & reset.
  - Latency, flush and reset behaviour are unchanged.

## Structure
- Package pipe_pkg: state enum (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2), default CTRL_W, bubble constant for control.
- One sub-module, pipe_slot: valid + ctrl + data register with load, clear and CLEAR_DATA handling.
  - Instantiated for main, and for skid when PIPE_STAGE_SKID_EN is defined.

## Test plan
- Reset: hold reset=0 for 3 cycles with inValid=1, inCtrl=12'hFFF → outValid=0, outCtrl=0, occupancy=0, inReady=0; one cycle after release, inReady=1.
- Streaming: inData 1..8 on consecutive cycles, outReady=1 → outData 1..8 exactly one cycle later, occupancy stays 1.
- Stall: outReady=0 for 4 cycles while sending 10,11,12 → 10 and 11 accepted, inReady=0 from the third cycle, 12 held upstream; release → outputs 10,11,12 in order, with no loss or duplicates.
- Flush while FULL: occupancy=2, assert syncClr with inValid=1, inData=99 → next cycle outValid=0, outCtrl=0, occupancy=0, inReady=1; 99 never appears.
- Simultaneous in/out in BUSY: main=5, in=6 with outReady=1 → next cycle outData=6, occupancy=1.
- Macro undefined: stall with outReady=0 → inReady=0 in the same cycle once occupancy=1; occupancy never reaches 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
// States encode occupancy directly (EMPTY=0, BUSY=1, FULL=2).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_CTRL_W = 12;

    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid flag plus control and data bundles.
// Flush zeroes control always and data only when CLEAR_DATA is set.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = PIPE_CTRL_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              drop,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Reset zeroes everything; clear beats load; drop only retires valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_W'(PIPE_CTRL_BUBBLE);
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(PIPE_CTRL_BUBBLE);
            if (CLEAR_DATA) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= dataIn;
            ctrl  <= ctrlIn;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush.
// PIPE_STAGE_SKID_EN adds a skid slot and a fully registered ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = PIPE_CTRL_W,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              syncClr,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [1:0]        occupancy
);

    pipe_state_e state;
    pipe_state_e stateNext;

    logic inXfer;
    logic outXfer;
    logic loadMain;
    logic dropMain;

    logic              mainValid;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainDataIn;
    logic [CTRL_W-1:0] mainCtrlIn;

`ifdef PIPE_STAGE_SKID_EN
    logic              loadSkid;
    logic              dropSkid;
    logic              mainFromSkid;
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    assign inReady    = (state != FULL) & reset;
    assign mainDataIn = mainFromSkid ? skidData : inData;
    assign mainCtrlIn = mainFromSkid ? skidCtrl : inCtrl;
`else
    assign inReady    = (~mainValid | outReady) & reset;
    assign mainDataIn = inData;
    assign mainCtrlIn = inCtrl;
`endif

    assign inXfer    = inValid & inReady;
    assign outXfer   = mainValid & outReady;
    assign outValid  = mainValid;
    assign occupancy = state;

    assign outCtrl = mainValid ? mainCtrl
                               : CTRL_W'(PIPE_CTRL_BUBBLE);

    // State register; reset wins over flush and transfers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and slot control; flush overrides every transfer.
    always_comb begin
        stateNext = state;
        loadMain  = 1'b0;
        dropMain  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        loadSkid     = 1'b0;
        dropSkid     = 1'b0;
        mainFromSkid = 1'b0;
`endif
        if (syncClr) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (inXfer) begin
                        stateNext = BUSY;
                        loadMain  = 1'b1;
                    end
                end
                BUSY: begin
                    if (inXfer && outXfer) begin
                        loadMain = 1'b1;
                    end else if (outXfer) begin
                        stateNext = EMPTY;
                        dropMain  = 1'b1;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (inXfer) begin
                        stateNext = FULL;
                        loadSkid  = 1'b1;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (outXfer) begin
                        stateNext    = BUSY;
                        loadMain     = skidValid;
                        mainFromSkid = 1'b1;
                        dropSkid     = 1'b1;
                    end
                end
`endif
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CLEAR_DATA(CLEAR_DATA)
    ) mainSlot (
        .clock (clock),
        .reset (reset),
        .load  (loadMain),
        .clear (syncClr),
        .drop  (dropMain),
        .dataIn(mainDataIn),
        .ctrlIn(mainCtrlIn),
        .valid (mainValid),
        .data  (outData),
        .ctrl  (mainCtrl)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .CLEAR_DATA(CLEAR_DATA)
    ) skidSlot (
        .clock (clock),
        .reset (reset),
        .load  (loadSkid),
        .clear (syncClr),
        .drop  (dropSkid),
        .dataIn(inData),
        .ctrlIn(inCtrl),
        .valid (skidValid),
        .data  (skidData),
        .ctrl  (skidCtrl)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (default or PIPE_STAGE_SKID_EN build).
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 12;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          syncClr  = 1'b0;
    logic          inValid  = 1'b0;
    logic          outReady = 1'b0;
    logic [DW-1:0] inData   = '0;
    logic [CW-1:0] inCtrl   = '0;
    logic          inReady;
    logic          outValid;
    logic [DW-1:0] outData;
    logic [CW-1:0] outCtrl;
    logic [1:0]    occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_stage_reg #(
        .DATA_W    (DW),
        .CTRL_W    (CW),
        .CLEAR_DATA(1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .syncClr  (syncClr),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .inCtrl   (inCtrl),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outCtrl  (outCtrl),
        .occupancy(occupancy)
    );

    function automatic logic [CW-1:0] ctl(input logic [31:0] d);
        return d[CW-1:0] | 12'h800;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        inValid = 1'b1;
        inData  = d;
        inCtrl  = ctl(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held with live input
        reset    = 1'b0;
        outReady = 1'b1;
        inValid  = 1'b1;
        inCtrl   = 12'hFFF;
        inData   = 32'd77;
        repeat (3) step();
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_outCtrl", 32'(outCtrl), 32'd0);
        chk("rst_outData", outData, 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_inReady", 32'(inReady), 32'd0);
        reset   = 1'b1;
        inValid = 1'b0;
        step();
        chk("rel_inReady", 32'(inReady), 32'd1);
        chk("rel_outValid", 32'(outValid), 32'd0);

        // streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            send(i);
            step();
            chk("str_data", outData, 32'(i));
            chk("str_ctrl", 32'(outCtrl), 32'(ctl(i)));
            chk("str_occ", 32'(occupancy), 32'd1);
        end
        inValid = 1'b0;
        step();
        chk("drain_valid", 32'(outValid), 32'd0);
        chk("drain_ctrl", 32'(outCtrl), 32'd0);
        chk("drain_occ", 32'(occupancy), 32'd0);

        // stall with 10, 11, 12
        outReady = 1'b0;
        send(10);
        #1;
        chk("stl_rdy0", 32'(inReady), 32'd1);
        step();
        chk("stl_d10", outData, 32'd10);
        chk("stl_occ1", 32'(occupancy), 32'd1);
`ifdef PIPE_STAGE_SKID_EN
        chk("stl_rdy1", 32'(inReady), 32'd1);
        send(11);
        step();
        chk("stl_occ2", 32'(occupancy), 32'd2);
        chk("stl_rdy2", 32'(inReady), 32'd0);
        chk("stl_hold10", outData, 32'd10);
        send(12);
        step();
        step();
        chk("stl_occ2b", 32'(occupancy), 32'd2);
        chk("stl_hold10b", outData, 32'd10);
        chk("stl_rdy3", 32'(inReady), 32'd0);
        outReady = 1'b1;
        step();
        chk("rls_d11", outData, 32'd11);
        chk("rls_occ1", 32'(occupancy), 32'd1);
        chk("rls_rdy", 32'(inReady), 32'd1);
        step();
        chk("rls_d12", outData, 32'd12);
        chk("rls_c12", 32'(outCtrl), 32'(ctl(12)));
`else
        chk("stl_rdy1", 32'(inReady), 32'd0);
        send(11);
        step();
        step();
        chk("stl_hold10", outData, 32'd10);
        chk("stl_occ1b", 32'(occupancy), 32'd1);
        chk("stl_rdy2", 32'(inReady), 32'd0);
        outReady = 1'b1;
        #1;
        chk("stl_rdy_pass", 32'(inReady), 32'd1);
        step();
        chk("rls_d11", outData, 32'd11);
        chk("rls_occ1", 32'(occupancy), 32'd1);
`endif
        inValid = 1'b0;
        step();
        chk("rls_empty", 32'(outValid), 32'd0);
        chk("rls_occ0", 32'(occupancy), 32'd0);

        // simultaneous in/out in BUSY
        send(5);
        step();
        chk("sim_d5", outData, 32'd5);
        send(6);
        step();
        chk("sim_d6", outData, 32'd6);
        chk("sim_occ", 32'(occupancy), 32'd1);

        // flush with a concurrent input
        outReady = 1'b0;
        send(20);
        step();
`ifdef PIPE_STAGE_SKID_EN
        send(21);
        step();
        chk("fl_occ2", 32'(occupancy), 32'd2);
`else
        chk("fl_occ1", 32'(occupancy), 32'd1);
`endif
        syncClr = 1'b1;
        send(99);
        step();
        chk("fl_valid", 32'(outValid), 32'd0);
        chk("fl_ctrl", 32'(outCtrl), 32'd0);
        chk("fl_data", outData, 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_rdy", 32'(inReady), 32'd1);
        syncClr  = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b1;
        step();
        chk("fl_no99", 32'(outValid), 32'd0);

        // reset beats flush and input
        send(7);
        step();
        chk("pre_d7", outData, 32'd7);
        reset   = 1'b0;
        syncClr = 1'b1;
        step();
        chk("rp_valid", 32'(outValid), 32'd0);
        chk("rp_data", outData, 32'd0);
        chk("rp_occ", 32'(occupancy), 32'd0);
        chk("rp_rdy", 32'(inReady), 32'd0);
        reset   = 1'b1;
        syncClr = 1'b0;
        inValid = 1'b0;
        step();
        chk("rp_rdy1", 32'(inReady), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
